// File: rtl/vga_timing_generator.sv
// VGA raster timing: free-running pixel/line counters with
// combinational decode of coordinates, blanking, sync and frame strobe.
module vga_timing_generator #(
    parameter int unsigned WIDTH         = 640,
    parameter int unsigned HEIGHT        = 480,
    parameter int unsigned H_FRONT_PORCH = 16,
    parameter int unsigned H_SYNC_WIDTH  = 96,
    parameter int unsigned H_BACK_PORCH  = 48,
    parameter int unsigned V_FRONT_PORCH = 10,
    parameter int unsigned V_SYNC_WIDTH  = 2,
    parameter int unsigned V_BACK_PORCH  = 33
) (
    input  logic       clk25,
    input  logic       reset,
    output logic       screenEnd,
    output logic       active,
    output logic       hSync,
    output logic       vSync,
    output logic [9:0] x,
    output logic [8:0] y
);

    localparam int unsigned H_TOTAL =
        WIDTH + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int unsigned V_TOTAL =
        HEIGHT + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(WIDTH);
    localparam logic [9:0] V_VIS    = 10'(HEIGHT);
    localparam logic [9:0] HS_START = 10'(WIDTH + H_FRONT_PORCH);
    localparam logic [9:0] HS_END   = 10'(WIDTH + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [9:0] VS_START = 10'(HEIGHT + V_FRONT_PORCH);
    localparam logic [9:0] VS_END   = 10'(HEIGHT + V_FRONT_PORCH + V_SYNC_WIDTH);

    logic [9:0] h_count;
    logic [9:0] v_count;

    always_ff @(posedge clk25) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;
        end else begin
            h_count <= h_count + 10'd1;
        end
    end

    // y deliberately drops bit 9; lines 512..524 alias to 0..12
    always_comb begin
        x         = h_count;
        y         = v_count[8:0];
        active    = (h_count < H_VIS) && (v_count < V_VIS);
        hSync     = !((h_count >= HS_START) && (h_count < HS_END));
        vSync     = !((v_count >= VS_START) && (v_count < VS_END));
        screenEnd = (h_count == 10'd0) && (v_count == V_VIS);
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: full-size and short-line instances
// checked every cycle against an arithmetic raster model.
module tb_vga_timing_generator;

    logic clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    logic       rst_a, rst_b;
    logic       se_a, act_a, hs_a, vs_a;
    logic       se_b, act_b, hs_b, vs_b;
    logic [9:0] x_a, x_b;
    logic [8:0] y_a, y_b;

    int checks = 0;
    int errors = 0;

    vga_timing_generator dut_a (
        .clk25(clk25), .reset(rst_a), .screenEnd(se_a), .active(act_a),
        .hSync(hs_a), .vSync(vs_a), .x(x_a), .y(y_a)
    );

    // short lines (8 pixels) keep a full 525-line frame at 4200 cycles
    vga_timing_generator #(
        .WIDTH(4), .H_FRONT_PORCH(1), .H_SYNC_WIDTH(2), .H_BACK_PORCH(1)
    ) dut_b (
        .clk25(clk25), .reset(rst_b), .screenEnd(se_b), .active(act_b),
        .hSync(hs_b), .vSync(vs_b), .x(x_b), .y(y_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk25);
        #1;
    endtask

    // model: cycles since reset mapped onto the raster by division
    int ta, tbc;
    bit ka = 1'b0, kb = 1'b0;

    always @(posedge clk25) begin
        if (rst_a) begin ta <= 0; ka <= 1'b1; end
        else ta <= ta + 1;
        if (rst_b) begin tbc <= 0; kb <= 1'b1; end
        else tbc <= tbc + 1;
    end

    task automatic cmp(input string tag, input int t, input int w,
                       input int hfp, input int hsw, input int hbp,
                       input logic se, input logic ac, input logic hs,
                       input logic vs, input logic [9:0] xx,
                       input logic [8:0] yy);
        int ht, h, v;
        ht = w + hfp + hsw + hbp;
        h  = t % ht;
        v  = (t / ht) % 525;
        chk({tag, "_x"}, int'(xx), h);
        chk({tag, "_y"}, int'(yy), v % 512);
        chk({tag, "_active"}, int'(ac), int'(h < w && v < 480));
        chk({tag, "_hsync"}, int'(hs),
            int'(!(h >= w + hfp && h < w + hfp + hsw)));
        chk({tag, "_vsync"}, int'(vs), int'(!(v >= 490 && v < 492)));
        chk({tag, "_screenend"}, int'(se), int'(h == 0 && v == 480));
    endtask

    always @(negedge clk25) begin
        if (ka) cmp("a", ta, 640, 16, 96, 48, se_a, act_a, hs_a, vs_a, x_a, y_a);
        if (kb) cmp("b", tbc, 4, 1, 2, 1, se_b, act_b, hs_b, vs_b, x_b, y_b);
    end

    task automatic seq_a();
        int act_n = 0, hs_n = 0, hs_first = -1, hs_last = -1, fall = -1;
        tick(1);
        chk("a_x_after_release", int'(x_a), 1);
        chk("a_y_after_release", int'(y_a), 0);
        for (int c = 1; c < 800; c++) begin
            if (act_a) act_n++;
            else if (fall < 0) fall = int'(x_a);
            if (!hs_a) begin
                hs_n++;
                if (hs_first < 0) hs_first = int'(x_a);
                hs_last = int'(x_a);
            end
            tick(1);
        end
        chk("a_line_wrap_x", int'(x_a), 0);
        chk("a_line_wrap_y", int'(y_a), 1);
        chk("a_active_line_count", act_n, 639);
        chk("a_active_fall_x", fall, 640);
        chk("a_hsync_low_count", hs_n, 96);
        chk("a_hsync_first_x", hs_first, 656);
        chk("a_hsync_last_x", hs_last, 751);
        tick(300);
        chk("a_pre_reset_x", int'(x_a), 300);
        rst_a = 1'b1;
        tick(1);
        chk("a_midreset_x", int'(x_a), 0);
        chk("a_midreset_y", int'(y_a), 0);
        chk("a_midreset_se", int'(se_a), 0);
        chk("a_midreset_active", int'(act_a), 1);
        rst_a = 1'b0;
        tick(1);
        chk("a_post_reset_x", int'(x_a), 1);
    endtask

    task automatic seq_b();
        int se_n = 0, se_first = -1, se_second = -1, vs_low = 0, act_n = 0;
        for (int c = 0; c < 8400; c++) begin
            if (se_b) begin
                se_n++;
                if (se_first < 0) se_first = c;
                else if (se_second < 0) se_second = c;
            end
            if (c < 4200) begin
                if (!vs_b) vs_low++;
                if (act_b) act_n++;
            end
            if (c == 3919) chk("b_vsync_before_490", int'(vs_b), 1);
            if (c == 3920) chk("b_vsync_at_490", int'(vs_b), 0);
            if (c == 4192) begin
                chk("b_y_line524", int'(y_b), 12);
                chk("b_x_line524", int'(x_b), 0);
            end
            if (c == 4199) begin
                chk("b_x_frame_last", int'(x_b), 7);
                chk("b_y_frame_last", int'(y_b), 12);
            end
            if (c == 4200) begin
                chk("b_frame_wrap_x", int'(x_b), 0);
                chk("b_frame_wrap_y", int'(y_b), 0);
                chk("b_frame_wrap_active", int'(act_b), 1);
            end
            tick(1);
        end
        chk("b_screenend_count", se_n, 2);
        chk("b_screenend_first", se_first, 3840);
        chk("b_screenend_period", se_second - se_first, 4200);
        chk("b_vsync_low_count", vs_low, 16);
        chk("b_active_per_frame", act_n, 1920);
        tick(1603);
        chk("b_pre_reset_x", int'(x_b), 3);
        chk("b_pre_reset_y", int'(y_b), 200);
        rst_b = 1'b1;
        tick(1);
        chk("b_midreset_x", int'(x_b), 0);
        chk("b_midreset_y", int'(y_b), 0);
        chk("b_midreset_se", int'(se_b), 0);
        rst_b = 1'b0;
        tick(2);
        chk("b_post_reset_x", int'(x_b), 2);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick(3);
        chk("rst_x", int'(x_a), 0);
        chk("rst_y", int'(y_a), 0);
        chk("rst_active", int'(act_a), 1);
        chk("rst_hsync", int'(hs_a), 1);
        chk("rst_vsync", int'(vs_a), 1);
        chk("rst_screenend", int'(se_a), 0);
        chk("rst_b_x", int'(x_b), 0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        fork
            seq_a();
            seq_b();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
